// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit.
// Optional beq support is enabled with MIPS_CTRL_BRANCH_EN.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;

    typedef logic [2:0] state_t;

    typedef enum logic [2:0] {
        CL_ILLEGAL,
        CL_RTYPE,
        CL_LW,
        CL_SW,
        CL_ADDI,
        CL_BEQ
    } iclass_e;

    function automatic iclass_e classify(
        input logic [5:0] op,
        input logic [5:0] funct
    );
        iclass_e c;
        c = CL_ILLEGAL;
        case (op)
            OP_RTYPE: begin
                if (funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT})
                    c = CL_RTYPE;
            end
            OP_LW:   c = CL_LW;
            OP_SW:   c = CL_SW;
            OP_ADDI: c = CL_ADDI;
`ifdef MIPS_CTRL_BRANCH_EN
            OP_BEQ:  c = CL_BEQ;
`else
            OP_BEQ:  c = CL_ILLEGAL;
`endif
            default: c = CL_ILLEGAL;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mips_alu_decode.sv
// ALU opcode lookup from instruction class and R-type funct.
// Pure combinational so pipelined control can reuse it.
module mips_alu_decode
    import mips_ctrl_pkg::*;
#(
    parameter int ALUW = 3
) (
    input  iclass_e         cls,
    input  logic [5:0]      funct,
    output logic [ALUW-1:0] alu_op
);

    always_comb begin
        alu_op = '0;
        unique case (1'b1)
            (cls == CL_RTYPE): begin
                case (funct)
                    FN_ADD:  alu_op = ALUW'(ALU_ADD);
                    FN_SUB:  alu_op = ALUW'(ALU_SUB);
                    FN_AND:  alu_op = ALUW'(ALU_AND);
                    FN_OR:   alu_op = ALUW'(ALU_OR);
                    FN_SLT:  alu_op = ALUW'(ALU_SLT);
                    default: alu_op = '0;
                endcase
            end
            (cls == CL_LW),
            (cls == CL_SW),
            (cls == CL_ADDI): alu_op = ALUW'(ALU_ADD);
            (cls == CL_BEQ):  alu_op = ALUW'(ALU_SUB);
            default:          alu_op = '0;
        endcase
    end

endmodule

// File: rtl/mips_control_fsm.sv
// Multi-cycle MIPS control FSM: IDLE/DECODE/EXEC/MEM/WB sequencing.
// Define MIPS_CTRL_BRANCH_EN to make beq legal and drive Branch.
module mips_control_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int IW   = 32,
    parameter int ALUW = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [IW-1:0]   I,
    input  logic            instr_valid,
    output logic            instr_ready,
    output logic [ALUW-1:0] opcode,
    output logic            RegW,
    output logic            Regdst,
    output logic            MemR,
    output logic            MemW,
    output logic            MemtoReg,
    output logic            ALUSrc,
    output logic            Branch,
    output logic            done,
    output logic            illegal
);

    if (IW != 32) begin : g_iw_check
        $error("mips_control_fsm: IW must be 32");
    end

    state_t          state;
    state_t          state_nx;
    logic [IW-1:0]   ir;
    iclass_e         cls;
    logic [ALUW-1:0] alu_op;
    logic            active;
    logic            unused_ir;

    assign cls       = classify(ir[31:26], ir[5:0]);
    assign unused_ir = ^ir[25:6];

    mips_alu_decode #(
        .ALUW (ALUW)
    ) u_alu_decode (
        .cls    (cls),
        .funct  (ir[5:0]),
        .alu_op (alu_op)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            ir    <= '0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && instr_valid)
                ir <= I;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (instr_valid)
                    state_nx = S_DECODE;
            end
            S_DECODE: begin
                state_nx = (cls == CL_ILLEGAL) ? S_IDLE : S_EXEC;
            end
            S_EXEC: begin
                case (cls)
                    CL_LW, CL_SW:      state_nx = S_MEM;
                    CL_RTYPE, CL_ADDI: state_nx = S_WB;
                    default:           state_nx = S_IDLE;
                endcase
            end
            S_MEM: begin
                state_nx = (cls == CL_LW) ? S_WB : S_IDLE;
            end
            S_WB:    state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Instruction-dependent controls only leave zero once decode is over.
    assign active = (state == S_EXEC) || (state == S_MEM) || (state == S_WB);

    assign instr_ready = (state == S_IDLE);
    assign opcode      = active ? alu_op : '0;
    assign ALUSrc      = active && (cls inside {CL_LW, CL_SW, CL_ADDI});
    assign Regdst      = active && (cls == CL_RTYPE);
    assign MemtoReg    = active && (cls == CL_LW);
    assign MemR        = ((state == S_MEM) || (state == S_WB))
                         && (cls == CL_LW);

    // Side effects are masked while rst is high so an abort never commits.
    assign MemW    = !rst && (state == S_MEM) && (cls == CL_SW);
    assign RegW    = !rst && (state == S_WB);
    assign illegal = !rst && (state == S_DECODE) && (cls == CL_ILLEGAL);

`ifdef MIPS_CTRL_BRANCH_EN
    assign Branch = (state == S_EXEC) && (cls == CL_BEQ);
    assign done   = !rst && ((state == S_WB)
                    || ((state == S_MEM) && (cls == CL_SW))
                    || ((state == S_EXEC) && (cls == CL_BEQ)));
`else
    assign Branch = 1'b0;
    assign done   = !rst && ((state == S_WB)
                    || ((state == S_MEM) && (cls == CL_SW)));
`endif

endmodule

// File: tb/tb_mips_control_fsm.sv
// Scoreboard bench for mips_control_fsm: expected control bundles
// are queued per instruction and checked by an independent monitor.
module tb_mips_control_fsm;

    typedef struct packed {
        logic       rdy;
        logic [2:0] op;
        logic       regw;
        logic       regdst;
        logic       memr;
        logic       memw;
        logic       m2r;
        logic       alusrc;
        logic       br;
        logic       dn;
        logic       ill;
    } bundle_t;

    typedef struct {
        bundle_t b;
        string   tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] I = 32'h0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [2:0]  opcode;
    logic        RegW, Regdst, MemR, MemW, MemtoReg, ALUSrc;
    logic        Branch, done, illegal;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   regw_seen = 0;
    int   memw_seen = 0;
    int   exp_regw = 0;
    int   exp_memw = 0;
    bit   mon_en = 0;
    bit   busy = 0;
    bit   prev_busy = 0;
    exp_t e;

    mips_control_fsm #(
        .IW   (32),
        .ALUW (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .I           (I),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .opcode      (opcode),
        .RegW        (RegW),
        .Regdst      (Regdst),
        .MemR        (MemR),
        .MemW        (MemW),
        .MemtoReg    (MemtoReg),
        .ALUSrc      (ALUSrc),
        .Branch      (Branch),
        .done        (done),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    function automatic bundle_t cur();
        return {instr_ready, opcode, RegW, Regdst, MemR, MemW,
                MemtoReg, ALUSrc, Branch, done, illegal};
    endfunction

    function automatic bundle_t mk(
        input logic rdy, input logic [2:0] op,
        input logic regw, input logic regdst, input logic memr,
        input logic memw, input logic m2r, input logic alusrc,
        input logic br, input logic dn, input logic ill);
        return {rdy, op, regw, regdst, memr, memw,
                m2r, alusrc, br, dn, ill};
    endfunction

    task automatic check(input string name, input bundle_t act,
                         input bundle_t req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got rdy/op/regw/regdst/memr/memw/m2r/alusrc/br/done/ill=%b required %b",
                     name, act, req);
        end
    endtask

    task automatic push(input bundle_t b, input string tag);
        exp_t x;
        x.b   = b;
        x.tag = tag;
        exp_q.push_back(x);
    endtask

    task automatic exp_idle(input string t);
        push(mk(1,3'b000,0,0,0,0,0,0,0,0,0), {t, "_idle"});
    endtask

    task automatic exp_decode(input string t);
        push(mk(0,3'b000,0,0,0,0,0,0,0,0,0), {t, "_decode"});
    endtask

    task automatic exp_rtype(input logic [2:0] op, input string t);
        exp_decode(t);
        push(mk(0,op,0,1,0,0,0,0,0,0,0), {t, "_exec"});
        push(mk(0,op,1,1,0,0,0,0,0,1,0), {t, "_wb"});
        exp_idle(t);
        exp_regw++;
    endtask

    task automatic exp_addi(input string t);
        exp_decode(t);
        push(mk(0,3'b010,0,0,0,0,0,1,0,0,0), {t, "_exec"});
        push(mk(0,3'b010,1,0,0,0,0,1,0,1,0), {t, "_wb"});
        exp_idle(t);
        exp_regw++;
    endtask

    task automatic exp_lw(input string t);
        exp_decode(t);
        push(mk(0,3'b010,0,0,0,0,1,1,0,0,0), {t, "_exec"});
        push(mk(0,3'b010,0,0,1,0,1,1,0,0,0), {t, "_mem"});
        push(mk(0,3'b010,1,0,1,0,1,1,0,1,0), {t, "_wb"});
        exp_idle(t);
        exp_regw++;
    endtask

    task automatic exp_sw(input string t);
        exp_decode(t);
        push(mk(0,3'b010,0,0,0,0,0,1,0,0,0), {t, "_exec"});
        push(mk(0,3'b010,0,0,0,1,0,1,0,1,0), {t, "_mem"});
        exp_idle(t);
        exp_memw++;
    endtask

    task automatic exp_illegal(input string t);
        push(mk(0,3'b000,0,0,0,0,0,0,0,0,1), {t, "_decode"});
        exp_idle(t);
    endtask

    task automatic issue(input logic [31:0] instr);
        @(posedge clk); #1;
        I = instr;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        I = ~instr;
    endtask

    task automatic drain(input string t);
        for (int k = 0; k < 40; k++) begin
            if (exp_q.size() == 0) return;
            @(negedge clk);
        end
        n_cmp++;
        n_bad++;
        $display("FAIL %s_timeout: got %0d pending entries required 0",
                 t, exp_q.size());
        exp_q.delete();
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            busy = !instr_ready;
            if (busy || prev_busy) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_output: got %b required no activity",
                             cur());
                end else begin
                    e = exp_q.pop_front();
                    check(e.tag, cur(), e.b);
                end
            end
            prev_busy = busy;
            if (MemW) memw_seen++;
            if (RegW) regw_seen++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset", cur(), mk(1,3'b000,0,0,0,0,0,0,0,0,0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_reset", cur(), mk(1,3'b000,0,0,0,0,0,0,0,0,0));
        mon_en = 1;

        exp_rtype(3'b010, "add");
        issue(32'h00221820);
        drain("add");

        exp_lw("lw");
        issue(32'h8C220004);
        drain("lw");

        exp_sw("sw");
        issue(32'hAC220004);
        drain("sw");

        exp_rtype(3'b000, "and");
        issue(32'h00221824);
        drain("and");

        exp_rtype(3'b111, "slt");
        issue(32'h0022182A);
        drain("slt");

        exp_addi("addi");
        issue(32'h20220005);
        drain("addi");

        exp_illegal("op3f");
        issue(32'hFC000000);
        drain("op3f");

        exp_illegal("fn3f");
        issue(32'h0000003F);
        drain("fn3f");

`ifdef MIPS_CTRL_BRANCH_EN
        exp_decode("beq");
        push(mk(0,3'b110,0,0,0,0,0,0,1,1,0), "beq_exec");
        exp_idle("beq");
`else
        exp_illegal("beq");
`endif
        issue(32'h10220003);
        drain("beq");

        exp_decode("abort");
        push(mk(0,3'b010,0,0,0,0,0,1,0,0,0), "abort_exec");
        exp_idle("abort");
        issue(32'hAC220004);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        drain("abort");

        exp_rtype(3'b010, "add2");
        issue(32'h00221820);
        drain("add2");

        exp_rtype(3'b110, "b2b_sub");
        exp_rtype(3'b001, "b2b_or");
        @(posedge clk); #1;
        I = 32'h00221822;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        I = 32'h00221825;
        begin : wait_idle
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (instr_ready) disable wait_idle;
            end
            n_cmp++;
            n_bad++;
            $display("FAIL b2b_ready: got instr_ready=0 required 1");
        end
        @(posedge clk); #1;
        instr_valid = 1'b0;
        drain("b2b");

        repeat (3) @(negedge clk);
        n_cmp++;
        if (regw_seen != exp_regw) begin
            n_bad++;
            $display("FAIL regw_count: got %0d required %0d",
                     regw_seen, exp_regw);
        end
        n_cmp++;
        if (memw_seen != exp_memw) begin
            n_bad++;
            $display("FAIL memw_count: got %0d required %0d",
                     memw_seen, exp_memw);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
